blink_ctrl: RTL and testbench

BLINK_CTRL -- requirements
Module: blink_ctrl

---
 rtl/blink_pkg.sv | 10 +
 rtl/blink_led_bounce.sv | 32 +++
 rtl/blink_ctrl.sv | 81 ++++++++
 tb/tb_blink_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// blink_pkg: shared mode constant, bounce direction type and half-period helper for blink_ctrl.
package blink_pkg;
  localparam int unsigned MODE_OFF = 0;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  function automatic int unsigned half_period(input int unsigned div_max, input int unsigned k);
    int unsigned h;
    h = (k == 0) ? 0 : div_max >> (k - 1);
    return (h == 0) ? 1 : h;
  endfunction
endpackage

// File: rtl/blink_led_bounce.sv
// led_bounce: one-hot ping-pong LED shifter; clear wins over load, load over step.
module led_bounce
  import blink_pkg::*;
#(
  parameter int LD_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step,
  input  logic            load,
  input  logic            clear,
  output logic [LD_W-1:0] LD
);
  logic [LD_W-1:0] ld_q, ld_d;
  dir_e            dir_q, dir_d;
  logic            go_up;
  always_comb begin
    go_up = (dir_q == DIR_UP) ? !ld_q[LD_W-1] : ld_q[0];
    ld_d  = clear ? '0 : load ? LD_W'(1) : step ? (go_up ? ld_q << 1 : ld_q >> 1) : ld_q;
    dir_d = (clear || load) ? DIR_UP : step ? (go_up ? DIR_UP : DIR_DOWN) : dir_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_q  <= '0;
      dir_q <= DIR_UP;
    end else begin
      ld_q  <= ld_d;
      dir_q <= dir_d;
    end
  end
  assign LD = ld_q;
endmodule

// File: rtl/blink_ctrl.sv
// blink_ctrl: switch-selected blink clock divider with ping-pong LED pattern.
// Define BLINK_CTRL_DEBOUNCE_EN to require DEB_CYCLES of stable switch input before a mode is accepted.
module blink_ctrl
  import blink_pkg::*;
#(
  parameter int SW_W       = 2,
  parameter int LD_W       = 16,
  parameter int DIV_MAX    = 1000,
  parameter int CNT_W      = 24,
  parameter int DEB_CYCLES = 16
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic [SW_W-1:0] SW,
  output logic            mode_clock,
  output logic            tick,
  output logic [LD_W-1:0] LD,
  output logic [SW_W-1:0] mode
);
  localparam logic [SW_W-1:0] OFF = SW_W'(MODE_OFF);
  if (DEB_CYCLES < 1 || LD_W < 2 || 64'(DIV_MAX) >= (64'(1) << CNT_W)) begin : g_bad_param
    $error("blink_ctrl: illegal parameter combination");
  end
  logic [SW_W-1:0]  sync1_q, mode_q, mode_nx;
  logic [CNT_W-1:0] cnt_q, cnt_d, h_cur;
  logic             mclk_q, mclk_d, tick_q, chg, wrap;
`ifdef BLINK_CTRL_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  logic [SW_W-1:0] sync2_q;
  logic [DW-1:0]   deb_q, deb_d;
  always_comb begin
    deb_d   = (sync1_q != sync2_q) ? '0 : (deb_q == DW'(DEB_CYCLES - 1)) ? deb_q : deb_q + 1'b1;
    mode_nx = (sync1_q == sync2_q && deb_q == DW'(DEB_CYCLES - 1)) ? sync2_q : mode_q;
  end
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sync2_q <= '0;
      deb_q   <= '0;
    end else begin
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
    end
  end
`else
  // mode_q doubles as the second synchronizer flop
  assign mode_nx = sync1_q;
`endif
  always_comb begin
    h_cur  = CNT_W'(half_period(DIV_MAX, 32'(mode_q)));
    chg    = mode_nx != mode_q;
    wrap   = (mode_q != OFF) && !chg && (cnt_q == h_cur - 1'b1);
    cnt_d  = (chg || mode_q == OFF || wrap) ? '0 : cnt_q + 1'b1;
    mclk_d = (mode_nx == OFF) ? 1'b0 : mclk_q ^ wrap;
  end
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= '0;
      mode_q  <= OFF;
      cnt_q   <= '0;
      mclk_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= SW;
      mode_q  <= mode_nx;
      cnt_q   <= cnt_d;
      mclk_q  <= mclk_d;
      tick_q  <= wrap;
    end
  end
  led_bounce #(.LD_W(LD_W)) u_led (
    .clk  (CLOCK),
    .rst  (RESET),
    .step (wrap && !mclk_q),
    .load (mode_q == OFF && mode_nx != OFF),
    .clear(mode_nx == OFF),
    .LD   (LD)
  );
  assign mode_clock = mclk_q;
  assign tick       = tick_q;
  assign mode       = mode_q;
endmodule

// File: tb/tb_blink_ctrl.sv
// tb_blink_ctrl: directed scoreboard bench for blink_ctrl (DIV_MAX=8, LD_W=4, DEB_CYCLES=4).
module tb_blink_ctrl;
  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] SW = 2'd0;
  logic       mode_clock, tick;
  logic [3:0] LD;
  logic [1:0] mode;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {int cyc; logic mclk; logic [3:0] ld;} exp_t;
  exp_t sb[$];
`ifdef BLINK_CTRL_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  blink_ctrl #(.SW_W(2), .LD_W(4), .DIV_MAX(8), .CNT_W(24), .DEB_CYCLES(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .SW(SW),
    .mode_clock(mode_clock), .tick(tick), .LD(LD), .mode(mode)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic m, input logic [3:0] l);
    exp_t e;
    e.cyc = c; e.mclk = m; e.ld = l;
    sb.push_back(e);
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge CLOCK);
  endtask

  task automatic chk_out(input string name, input int m, input int mc, input int l);
    chk({name, "_mode"}, mode, m);
    chk({name, "_mclk"}, mode_clock, mc);
    chk({name, "_ld"}, LD, l);
  endtask

  // monitor: every tick must match the next scoreboard entry
  always @(negedge CLOCK) begin
    if (tick) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_tick: tick=1 at cycle %0d, required 0", cyc);
      end else begin : pop
        exp_t e;
        e = sb.pop_front();
        chk("tick_cycle", cyc, e.cyc);
        chk("tick_mclk", mode_clock, e.mclk);
        chk("tick_ld", LD, e.ld);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before time 200000");
    $fatal(1);
  end

  initial begin
    int r0, b, m, d, e, f, r;
    repeat (2) @(negedge CLOCK);
    #1;
    chk_out("reset", 0, 0, 0);
    chk("reset_tick", tick, 0);
    @(negedge CLOCK);
    RESET = 1'b0;
    r0 = cyc;
    goto(r0 + 4);
    chk_out("idle", 0, 0, 0);
`ifdef BLINK_CTRL_DEBOUNCE_EN
    b = cyc;
    SW = 2'd1;
    goto(b + 3);
    SW = 2'd0;
    goto(b + 8);
    chk("glitch_mode", mode, 0);
`endif
    // mode 1: H=8
    b = cyc + LAT;
    SW = 2'd1;
    push(b + 8, 1, 4'b0010);
    push(b + 16, 0, 4'b0010);
    push(b + 24, 1, 4'b0100);
    push(b + 32, 0, 4'b0100);
    goto(b - 1);
    chk("mode1_latency", mode, 0);
    goto(b);
    chk_out("mode1_entry", 1, 0, 1);
    // 1 -> 2 with counter at 5
    m = b + 37;
    goto(m - LAT);
    SW = 2'd2;
    push(m + 4, 1, 4'b1000);
    push(m + 8, 0, 4'b1000);
    push(m + 12, 1, 4'b0100);
    push(m + 16, 0, 4'b0100);
    goto(m);
    chk_out("mode2_entry", 2, 0, 4'b0100);
    // 2 -> 3: H=2, bounce off bit 0
    d = m + 17;
    goto(d - LAT);
    SW = 2'd3;
    push(d + 2, 1, 4'b0010);
    push(d + 4, 0, 4'b0010);
    push(d + 6, 1, 4'b0001);
    push(d + 8, 0, 4'b0001);
    push(d + 10, 1, 4'b0010);
    push(d + 12, 0, 4'b0010);
    push(d + 14, 1, 4'b0100);
    push(d + 16, 0, 4'b0100);
    goto(d);
    chk("mode3_entry", mode, 3);
    // 3 -> 0
    e = d + 17;
    goto(e - LAT);
    SW = 2'd0;
    goto(e);
    chk_out("mode0_entry", 0, 0, 0);
    goto(e + 10);
    chk_out("mode0_hold", 0, 0, 0);
    // 0 -> 1 reloads bit 0
    f = e + 12;
    goto(f - LAT);
    SW = 2'd1;
    push(f + 8, 1, 4'b0010);
    push(f + 16, 0, 4'b0010);
    push(f + 24, 1, 4'b0100);
    goto(f);
    chk_out("reload", 1, 0, 1);
    goto(f + 26);
    chk_out("pre_reset", 1, 1, 4'b0100);
    RESET = 1'b1;
    #1;
    chk_out("async_reset", 0, 0, 0);
    chk("async_reset_tick", tick, 0);
    @(negedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;
    r = cyc;
    push(r + LAT + 8, 1, 4'b0010);
    goto(r + LAT - 1);
    chk("post_reset_mode", mode, 0);
    goto(r + LAT);
    chk_out("post_reset_entry", 1, 0, 1);
    goto(r + LAT + 12);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
